// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU Z-stage types and defaults.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int TIMEOUT = 40;
    typedef enum logic [1:0] {IDLE, WAIT, FULL} z_state_t;
endpackage

// File: rtl/alu_z_result_stage_if.sv
// alu_z_result_stage_if: ALU result/launch inputs and Z-stage bus/status outputs.
interface alu_z_result_stage_if #(parameter int DATA_W = alu_pkg::DATA_W);
    logic              in_start;
    logic              in_multi;
    logic              in_wide;
    logic [DATA_W-1:0] in_result_lo;
    logic [DATA_W-1:0] in_result_hi;
    logic              in_done;
    logic              in_zlo_out;
    logic              in_zhi_out;
    logic [DATA_W-1:0] out_bus;
    logic              out_drive;
    logic              out_valid;
    logic              out_busy;
    logic              out_zero;
    logic              out_neg;
    logic              out_err;
    modport master (
        output in_start, in_multi, in_wide, in_result_lo, in_result_hi, in_done, in_zlo_out, in_zhi_out,
        input  out_bus, out_drive, out_valid, out_busy, out_zero, out_neg, out_err
    );
    modport slave (
        input  in_start, in_multi, in_wide, in_result_lo, in_result_hi, in_done, in_zlo_out, in_zhi_out,
        output out_bus, out_drive, out_valid, out_busy, out_zero, out_neg, out_err
    );
endinterface

// File: rtl/z_flag_gen.sv
// z_flag_gen: zero/negative flags of a 64-bit or 32-bit (low half) result.
module z_flag_gen #(parameter int DATA_W = alu_pkg::DATA_W) (
    input  logic [2*DATA_W-1:0] value,
    input  logic                wide,
    output logic                zero,
    output logic                neg
);
    always_comb begin
        zero = wide ? (value == '0) : (value[DATA_W-1:0] == '0);
        neg  = wide ? value[2*DATA_W-1] : value[DATA_W-1];
    end
endmodule

// File: rtl/alu_z_result_stage.sv
// alu_z_result_stage: captures ALU results into ZHi:ZLo and drains them onto the bus.
// Optional WAIT timeout abort enabled by defining ALU_Z_TIMEOUT_EN.
module alu_z_result_stage #(
    parameter int DATA_W = alu_pkg::DATA_W
`ifdef ALU_Z_TIMEOUT_EN
    , parameter int TIMEOUT = alu_pkg::TIMEOUT
`endif
) (
    input logic in_clk,
    input logic in_rst,
    alu_z_result_stage_if.slave z
);
    import alu_pkg::*;

    z_state_t          state, state_n;
    logic [DATA_W-1:0] zlo, zhi, zlo_n, zhi_n;
    logic              wide, wide_n, lo_read, lo_read_n, hi_read, hi_read_n;
    logic              zero, neg, cap, cap_zero, cap_neg, rd_lo, rd_hi;
`ifdef ALU_Z_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err, err_set;
`endif

    z_flag_gen #(.DATA_W(DATA_W)) u_flags (
        .value({zhi_n, zlo_n}),
        .wide (wide_n),
        .zero (cap_zero),
        .neg  (cap_neg)
    );

    always_comb begin
        state_n   = state;
        zlo_n     = zlo;
        zhi_n     = zhi;
        wide_n    = wide;
        lo_read_n = lo_read;
        hi_read_n = hi_read;
        cap       = 1'b0;
`ifdef ALU_Z_TIMEOUT_EN
        err_set   = 1'b0;
`endif
        // A new launch abandons whatever is pending, from any state
        if (z.in_start) begin
            wide_n    = z.in_wide;
            lo_read_n = 1'b0;
            hi_read_n = 1'b0;
            if (z.in_multi) begin
                state_n = WAIT;
            end else begin
                zlo_n   = z.in_result_lo;
                zhi_n   = z.in_wide ? z.in_result_hi : '0;
                cap     = 1'b1;
                state_n = FULL;
            end
        end else if (state == WAIT) begin
            if (z.in_done) begin
                zlo_n   = z.in_result_lo;
                zhi_n   = wide ? z.in_result_hi : '0;
                cap     = 1'b1;
                state_n = FULL;
            end
`ifdef ALU_Z_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
                zlo_n   = '0;
                zhi_n   = '0;
                cap     = 1'b1;
                err_set = 1'b1;
                state_n = FULL;
            end
`endif
        end else if (state == FULL) begin
            lo_read_n = lo_read | rd_lo;
            hi_read_n = hi_read | rd_hi;
            if (wide ? (lo_read_n & hi_read_n) : rd_lo) begin
                state_n   = IDLE;
                lo_read_n = 1'b0;
                hi_read_n = 1'b0;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state   <= IDLE;
            zlo     <= '0;
            zhi     <= '0;
            wide    <= 1'b0;
            lo_read <= 1'b0;
            hi_read <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            state   <= state_n;
            zlo     <= zlo_n;
            zhi     <= zhi_n;
            wide    <= wide_n;
            lo_read <= lo_read_n;
            hi_read <= hi_read_n;
            if (cap) begin
                zero <= cap_zero;
                neg  <= cap_neg;
            end
        end
    end

`ifdef ALU_Z_TIMEOUT_EN
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == WAIT && state_n == WAIT && !z.in_start) ? cnt + 1'b1 : '0;
            err <= err | err_set;
        end
    end
    assign z.out_err = err;
`else
    assign z.out_err = 1'b0;
`endif

    always_comb begin
        rd_lo       = (state == FULL) && z.in_zlo_out;
        rd_hi       = (state == FULL) && !z.in_zlo_out && z.in_zhi_out && wide;
        z.out_drive = rd_lo | rd_hi;
        z.out_bus   = rd_lo ? zlo : rd_hi ? zhi : '0;
        z.out_valid = state == FULL;
        z.out_busy  = state == WAIT;
        z.out_zero  = zero;
        z.out_neg   = neg;
    end
endmodule

// File: tb/tb_alu_z_result_stage.sv
// tb_alu_z_result_stage: directed self-checking bench for alu_z_result_stage.
module tb_alu_z_result_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_z_result_stage_if zif();
    alu_z_result_stage dut (.in_clk(clk), .in_rst(rst), .z(zif));

    always #5 clk = ~clk;

    // status order: {valid, busy, zero, neg, err, drive}
    logic [5:0] st;
    assign st = {zif.out_valid, zif.out_busy, zif.out_zero, zif.out_neg, zif.out_err, zif.out_drive};

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_in();
        zif.in_start = 0; zif.in_multi = 0; zif.in_wide = 0;
        zif.in_result_lo = '0; zif.in_result_hi = '0; zif.in_done = 0;
        zif.in_zlo_out = 0; zif.in_zhi_out = 0;
    endtask

    task automatic launch(input logic multi, input logic wide, input logic [31:0] hi, input logic [31:0] lo);
        zif.in_start = 1; zif.in_multi = multi; zif.in_wide = wide;
        zif.in_result_hi = hi; zif.in_result_lo = lo;
        cyc();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        cyc();
        n_chk++; if (st !== 6'b000000) begin n_fail++; $display("FAIL reset_status got %b expected %b", st, 6'b000000); end
        n_chk++; if (zif.out_bus !== 32'h0) begin n_fail++; $display("FAIL reset_bus got %h expected %h", zif.out_bus, 32'h0); end
    endtask

    task automatic test_narrow_shift();
        launch(0, 0, 32'hDEAD_BEEF, 32'h8000_0078);
        n_chk++; if (st !== 6'b100100) begin n_fail++; $display("FAIL narrow_capture got %b expected %b", st, 6'b100100); end
        zif.in_zlo_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h8000_0078 || st !== 6'b100101) begin n_fail++; $display("FAIL narrow_read bus %h st %b expected %h %b", zif.out_bus, st, 32'h8000_0078, 6'b100101); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (st !== 6'b000100) begin n_fail++; $display("FAIL narrow_drained got %b expected %b", st, 6'b000100); end
    endtask

    task automatic test_rotate_zero();
        launch(0, 0, 32'h1234_5678, 32'h0);
        n_chk++; if (st !== 6'b101000) begin n_fail++; $display("FAIL zero_capture got %b expected %b", st, 6'b101000); end
        zif.in_zhi_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h0 || st !== 6'b101000) begin n_fail++; $display("FAIL zero_zhi_ignored bus %h st %b expected %h %b", zif.out_bus, st, 32'h0, 6'b101000); end
        cyc(); zif.in_zhi_out = 0; zif.in_zlo_out = 1; #1;
        n_chk++; if (st !== 6'b101001) begin n_fail++; $display("FAIL zero_read got %b expected %b", st, 6'b101001); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (st !== 6'b001000) begin n_fail++; $display("FAIL zero_drained got %b expected %b", st, 6'b001000); end
    endtask

    task automatic test_mul_wide();
        launch(1, 1, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            n_chk++; if (st !== 6'b011000) begin n_fail++; $display("FAIL mul_busy cycle %0d got %b expected %b", i, st, 6'b011000); end
            if (i == 31) begin zif.in_done = 1; zif.in_result_hi = 32'h0000_0001; zif.in_result_lo = 32'hFFFF_FFFE; end
            cyc();
        end
        clear_in(); #1;
        n_chk++; if (st !== 6'b100000) begin n_fail++; $display("FAIL mul_capture got %b expected %b", st, 6'b100000); end
        zif.in_zhi_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h0000_0001 || !zif.out_drive) begin n_fail++; $display("FAIL mul_read_hi bus %h drive %b expected %h 1", zif.out_bus, zif.out_drive, 32'h1); end
        cyc(); zif.in_zhi_out = 0; #1;
        n_chk++; if (st !== 6'b100000) begin n_fail++; $display("FAIL mul_after_hi got %b expected %b", st, 6'b100000); end
        zif.in_zlo_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'hFFFF_FFFE || !zif.out_drive) begin n_fail++; $display("FAIL mul_read_lo bus %h drive %b expected %h 1", zif.out_bus, zif.out_drive, 32'hFFFF_FFFE); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (st !== 6'b000000) begin n_fail++; $display("FAIL mul_drained got %b expected %b", st, 6'b000000); end
    endtask

    task automatic test_simul_strobes();
        launch(0, 1, 32'h8000_0000, 32'h0000_0005);
        n_chk++; if (st !== 6'b100100) begin n_fail++; $display("FAIL both_capture got %b expected %b", st, 6'b100100); end
        zif.in_zlo_out = 1; zif.in_zhi_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h5) begin n_fail++; $display("FAIL both_lo_wins got %h expected %h", zif.out_bus, 32'h5); end
        cyc(); zif.in_zhi_out = 0; #1;
        n_chk++; if (st !== 6'b100101 || zif.out_bus !== 32'h5) begin n_fail++; $display("FAIL both_reread st %b bus %h expected %b %h", st, zif.out_bus, 6'b100101, 32'h5); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (st !== 6'b100100) begin n_fail++; $display("FAIL both_still_full got %b expected %b", st, 6'b100100); end
        zif.in_zhi_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h8000_0000) begin n_fail++; $display("FAIL both_read_hi got %h expected %h", zif.out_bus, 32'h8000_0000); end
        cyc(); zif.in_zhi_out = 0; #1;
        n_chk++; if (st !== 6'b000100) begin n_fail++; $display("FAIL both_drained got %b expected %b", st, 6'b000100); end
    endtask

    task automatic test_overwrite();
        launch(0, 1, 32'h0000_BBBB, 32'h0000_AAAA);
        zif.in_zlo_out = 1;
        cyc(); zif.in_zlo_out = 0;
        launch(0, 1, 32'h0, 32'h1E00_0001);
        n_chk++; if (st !== 6'b100000) begin n_fail++; $display("FAIL ovw_capture got %b expected %b", st, 6'b100000); end
        zif.in_zhi_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h0 || !zif.out_drive) begin n_fail++; $display("FAIL ovw_read_hi bus %h drive %b expected 0 1", zif.out_bus, zif.out_drive); end
        cyc(); zif.in_zhi_out = 0; #1;
        n_chk++; if (st !== 6'b100000) begin n_fail++; $display("FAIL ovw_lo_read_cleared got %b expected %b", st, 6'b100000); end
        zif.in_zlo_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h1E00_0001) begin n_fail++; $display("FAIL ovw_read_lo got %h expected %h", zif.out_bus, 32'h1E00_0001); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (st !== 6'b000000) begin n_fail++; $display("FAIL ovw_drained got %b expected %b", st, 6'b000000); end
    endtask

    task automatic test_reset_wait();
        launch(0, 0, 32'h0, 32'h8000_0000);
        launch(1, 0, 32'h0, 32'h0);
        n_chk++; if (st !== 6'b010100) begin n_fail++; $display("FAIL rw_busy got %b expected %b", st, 6'b010100); end
        rst = 1;
        cyc(); rst = 0; #1;
        n_chk++; if (st !== 6'b000000 || zif.out_bus !== 32'h0) begin n_fail++; $display("FAIL rw_reset st %b bus %h expected %b 0", st, zif.out_bus, 6'b000000); end
        zif.in_done = 1; zif.in_result_lo = 32'h1234;
        cyc(); clear_in(); #1;
        n_chk++; if (st !== 6'b000000) begin n_fail++; $display("FAIL rw_done_ignored got %b expected %b", st, 6'b000000); end
    endtask

`ifdef ALU_Z_TIMEOUT_EN
    task automatic test_timeout();
        launch(1, 1, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            n_chk++; if (st[4] !== 1'b1) begin n_fail++; $display("FAIL to_busy cycle %0d got %b expected 1", i, st[4]); end
            cyc();
        end
        n_chk++; if (st !== 6'b101010) begin n_fail++; $display("FAIL to_abort got %b expected %b", st, 6'b101010); end
        zif.in_zlo_out = 1; #1;
        n_chk++; if (zif.out_bus !== 32'h0 || !zif.out_drive) begin n_fail++; $display("FAIL to_read bus %h drive %b expected 0 1", zif.out_bus, zif.out_drive); end
        cyc(); zif.in_zlo_out = 0; #1;
        n_chk++; if (zif.out_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b expected 1", zif.out_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_narrow_shift();
        test_rotate_zero();
        test_mul_wide();
        test_simul_strobes();
        test_overwrite();
        test_reset_wait();
`ifdef ALU_Z_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_z_result_stage.md
Name: alu_z_result_stage

Overview:
Result-capture stage directly downstream of the ALU result mux, which includes the shift/rotate unit.
- Latches single-cycle ALU results, e.g. shift/rotate output, into ZLo.
- Latches multi-cycle multiply/divide results into the ZHi:ZLo pair.
- Computes zero/negative flags at capture.
- Drains the pair onto the 32-bit datapath bus under bus-read strobes, holding the result until consumed.

Parameters:
DATA_W, 32, width of bus and of each Z half
TIMEOUT, 40, max cycles in WAIT before forced abort (only with ALU_Z_TIMEOUT_EN)

Ports:
in_clk  input  1  clock; all state updates on rising edge
in_rst  input  1  synchronous reset, active-high
in_start  input  1  one-cycle pulse: ALU op launched this cycle
in_multi  input  1  qualifies in_start: op is iterative (mul/div); result arrives with in_done
in_wide  input  1  qualifies in_start: result is 64-bit (ZHi meaningful)
in_result_lo  input  DATA_W  low result word (shift/rotate/logic/arith, or mul/div low)
in_result_hi  input  DATA_W  high result word (mul high / div remainder)
in_done  input  1  iterative unit result valid this cycle
in_zlo_out  input  1  bus requests ZLo this cycle
in_zhi_out  input  1  bus requests ZHi this cycle
out_bus  output  DATA_W  selected Z half, zero when not driving
out_drive  output  1  high when out_bus carries a valid Z half
out_valid  output  1  result held and not fully drained
out_busy  output  1  waiting on iterative unit
out_zero  output  1  captured result == 0
out_neg  output  1  MSB of captured result
out_err  output  1  sticky timeout flag (tied 0 without ALU_Z_TIMEOUT_EN)

Behaviour:
- Reset (in_rst=1 at edge, any state, overrides all inputs):
  - state=IDLE; ZLo=ZHi=0; wide flag=0; lo_read=hi_read=0.
  - out_valid=out_busy=out_drive=out_zero=out_neg=out_err=0; out_bus=0.
- FSM states: IDLE, WAIT, FULL. wide flag registered from in_wide at in_start.
- IDLE:
  - in_start & !in_multi: capture in_result_lo into ZLo; ZHi=in_wide ? in_result_hi : 0; -> FULL. out_valid high next cycle (1-cycle latency).
  - in_start & in_multi: -> WAIT; out_busy=1 next cycle.
- WAIT:
  - in_done: capture both words -> FULL. out_busy drops and out_valid rises the same following cycle.
  - in_done in the same cycle as entering WAIT is ignored.
- FULL, read-strobe handling (combinational drive, registered bookkeeping):
  - in_zlo_out: out_bus=ZLo, out_drive=1.
  - else in_zhi_out & wide: out_bus=ZHi, out_drive=1.
  - Both strobes in one cycle: ZLo wins; ZHi must be requested again.
  - in_zhi_out on a narrow result: out_drive=0, out_bus=0, ignored.
  - Reading an already-read half is allowed, re-drives same value, no state change.
- FULL -> IDLE, at the edge completing drain:
  - narrow: after first ZLo read.
  - wide: once lo_read and hi_read are both set, in either order.
  - out_valid falls the next cycle.
- in_start while in WAIT or FULL:
  - Abandons the current result/wait.
  - Processed exactly as from IDLE at the same edge.
  - Clears lo_read and hi_read.
- Flags, registered at capture only, held until next capture or reset:
  - out_zero = (wide ? {ZHi,ZLo} : ZLo) == 0.
  - out_neg = wide ? ZHi[DATA_W-1] : ZLo[DATA_W-1].
- Outside FULL: out_drive=0, out_bus=0; read strobes ignored.

Optional Feature:
ALU_Z_TIMEOUT_EN:
- Defined:
  - cycle counter runs in WAIT, cleared on entry.
  - If TIMEOUT cycles elapse without in_done: ZLo=ZHi=0, flags recomputed (zero=1), out_err set sticky, -> FULL.
  - out_err cleared only by reset.
- Undefined: no counter; WAIT persists indefinitely; out_err tied 0.

Decomposition:
- Shared package alu_pkg:
  - z_state_t enum (IDLE, WAIT, FULL)
  - DATA_W default
  - TIMEOUT default
- Sub-module z_flag_gen (combinational zero/neg from 64-bit value + wide flag); reused by future condition-code logic.
- FSM and registers stay in alu_z_result_stage.

Test Plan:
- Single-cycle shift, narrow:
  - Stimulus: start, multi=0, wide=0, lo=0x80000078.
  - Response: next cycle valid=1, neg=1, zero=0; zlo_out -> bus=0x80000078, drive=1; following cycle valid=0.
- Rotate-to-zero shift, narrow:
  - Stimulus: start, lo=0x00000000.
  - Response: zero=1, neg=0; zhi_out ignored (drive=0); zlo_out drains.
- Multi-cycle mul, wide:
  - Stimulus: start, multi=1, wide=1; done after 32 cycles with hi=0x00000001, lo=0xFFFFFFFE.
  - Response: busy for 32 cycles; then valid=1, zero=0, neg=0; zhi_out -> 0x00000001; zlo_out -> 0xFFFFFFFE; IDLE after second read.
- Simultaneous strobes on wide result:
  - Stimulus: zlo_out=zhi_out=1.
  - Response: bus=ZLo; stays FULL until a later zhi_out.
- Overwrite: in_start with lo=0x1E000001 while FULL and undrained → old result lost; new capture next cycle, lo_read cleared.
- Reset mid-WAIT: in_rst pulse → all outputs 0, IDLE; a later in_done is ignored.
- With ALU_Z_TIMEOUT_EN:
  - Stimulus: no in_done for 40 cycles.
  - Response: err=1, zero=1, valid=1, bus=0 on zlo_out.
